layer_motion_updater: RTL and testbench

Frame-start header maintenance engine for the GPU layer-header store. On each frame-start pulse it walks all 32 layer headers through the header store's controller port. For every populated sprite layer it adds X/Y velocity to X/Y position and advances the animation frame. It does this before any pixel processing of the new frame. It sits directly upstream of the layer-header block, in front of its controller read/write port. An external mux gives it that port while `busy` is high.

---
 rtl/gpu_layer_pkg.sv | 42 ++++
 rtl/layer_motion_residue_ram.sv | 36 +++
 rtl/layer_motion_updater.sv | 246 ++++++++++++++++++++++++
 tb/tb_layer_motion_updater.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_layer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gpu_layer_pkg
// Purpose  : Shared layer-header register map, flag bit positions and the
//            motion-updater FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_layer_pkg;

   // Header register indices touched by the motion updater
   localparam logic [2:0] IDX_FLAGS = 3'd0;
   localparam logic [2:0] IDX_XPOS  = 3'd3;
   localparam logic [2:0] IDX_YPOS  = 3'd4;
   localparam logic [2:0] IDX_XVEL  = 3'd5;
   localparam logic [2:0] IDX_YVEL  = 3'd6;
   localparam logic [2:0] IDX_FRAME = 3'd7;

   // Bit positions inside the flags register
   localparam int FLAG_POPULATED = 0;
   localparam int FLAG_SPRITE    = 1;
   localparam int FLAG_ANIMATED  = 3;

   // Highest layer number in the header store
   localparam logic [4:0] LAST_LAYER = 5'd31;

   // Motion updater FSM states
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_RD_FLAGS = 4'd1,
      ST_RD_XPOS  = 4'd2,
      ST_RD_XVEL  = 4'd3,
      ST_WR_XPOS  = 4'd4,
      ST_RD_YPOS  = 4'd5,
      ST_RD_YVEL  = 4'd6,
      ST_WR_YPOS  = 4'd7,
      ST_RD_FRAME = 4'd8,
      ST_WR_FRAME = 4'd9,
      ST_DONE     = 4'd10
   } motion_state_t;

endpackage
`default_nettype wire

// File: rtl/layer_motion_residue_ram.sv
`default_nettype none
// ============================================================================
// Module   : layer_motion_residue_ram
// Purpose  : Per-layer sub-pixel residue store. One entry per layer holding
//            {Y residue, X residue}. Synchronous write, combinational read,
//            synchronous clear of every entry on reset.
// Revision : 1.0 - initial release
// ============================================================================
module layer_motion_residue_ram #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       i_addr,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] r_mem [32];

   // Clear all entries on reset, otherwise write the addressed entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/layer_motion_updater.sv
`default_nettype none
// ============================================================================
// Module   : layer_motion_updater
// Purpose  : Frame-start pass over all 32 layer headers. Sprite layers get
//            velocity added to position (with a fractional residue kept
//            locally) and, on animation ticks, their animation frame stepped.
// Revision : 1.0 - initial release
// ============================================================================
module layer_motion_updater
   import gpu_layer_pkg::*;
#(
   parameter int VEL_SHIFT = 6,
   parameter int ANIM_DIV  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frameStart,
   input  logic [15:0] ctrlReadData,
   output logic [4:0]  ctrlReadWriteLayer,
   output logic [2:0]  layerRegisterIndex,
   output logic [15:0] writeLayerData,
   output logic        writeLayerEn,
   output logic        busy,
   output logic        updateDone,
   output logic        frameOverrun
);

   localparam int         ACC_W     = 16 + VEL_SHIFT;
   localparam int         RES_W     = VEL_SHIFT;
   localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

   motion_state_t r_state;
   motion_state_t w_next_state;

   logic [4:0]       r_layer;
   logic [7:0]       r_animCount;
   logic             r_animTick;
   logic             r_animated;
   logic [15:0]      r_pos;
   logic [ACC_W-1:0] r_acc;
   logic [15:0]      r_frameWord;
   logic             r_overrun;

   logic             w_layerEnd;
   logic [2*RES_W-1:0] w_resRd;
   logic [2*RES_W-1:0] w_resWd;
   logic             w_resWe;
   logic [RES_W-1:0] w_curRes;
   logic [ACC_W-1:0] w_accSum;
   logic [8:0]       w_frameInc;
   logic [7:0]       w_nextFrame;

   layer_motion_residue_ram #(
      .WIDTH (2 * RES_W)
   ) u_residue_ram (
      .clk       (clk),
      .rst       (reset),
      .i_addr    (r_layer),
      .i_we      (w_resWe),
      .i_wr_data (w_resWd),
      .o_rd_data (w_resRd)
   );

   // Fixed-point accumulate: {pos, residue} plus sign-extended velocity, wrapping
   assign w_curRes = (r_state == ST_RD_YVEL) ? w_resRd[2*RES_W-1:RES_W] : w_resRd[RES_W-1:0];
   assign w_accSum = {r_pos, w_curRes} + {{RES_W{ctrlReadData[15]}}, ctrlReadData};

   // Frame step; the 9-bit increment also folds an out-of-range frame back to 0
   assign w_frameInc  = {1'b0, r_frameWord[15:8]} + 9'd1;
   assign w_nextFrame = (w_frameInc >= {1'b0, r_frameWord[7:0]}) ? 8'd0 : w_frameInc[7:0];

   assign busy         = (r_state != ST_IDLE);
   assign updateDone   = (r_state == ST_DONE);
   assign frameOverrun = r_overrun;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; w_layerEnd marks the last cycle spent on a layer
   always_comb begin
      w_next_state = r_state;
      w_layerEnd   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (frameStart) begin
               w_next_state = ST_RD_FLAGS;
            end
         end
         ST_RD_FLAGS: begin
            if (!ctrlReadData[FLAG_POPULATED] || !ctrlReadData[FLAG_SPRITE]) begin
               w_layerEnd = 1'b1;
            end else begin
               w_next_state = ST_RD_XPOS;
            end
         end
         ST_RD_XPOS: w_next_state = ST_RD_XVEL;
         ST_RD_XVEL: w_next_state = ST_WR_XPOS;
         ST_WR_XPOS: w_next_state = ST_RD_YPOS;
         ST_RD_YPOS: w_next_state = ST_RD_YVEL;
         ST_RD_YVEL: w_next_state = ST_WR_YPOS;
         ST_WR_YPOS: begin
            if (r_animTick && r_animated) begin
               w_next_state = ST_RD_FRAME;
            end else begin
               w_layerEnd = 1'b1;
            end
         end
         ST_RD_FRAME: begin
            if (ctrlReadData[7:0] != 8'd0) begin
               w_next_state = ST_WR_FRAME;
            end else begin
               w_layerEnd = 1'b1;
            end
         end
         ST_WR_FRAME: w_layerEnd = 1'b1;
         ST_DONE:     w_next_state = ST_IDLE;
         default:     w_next_state = ST_IDLE;
      endcase
      if (w_layerEnd) begin
         w_next_state = (r_layer == LAST_LAYER) ? ST_DONE : ST_RD_FLAGS;
      end
   end

   // Header-port outputs; writes are suppressed in a cycle where reset is high
   always_comb begin
      ctrlReadWriteLayer = 5'd0;
      layerRegisterIndex = 3'd0;
      writeLayerData     = 16'd0;
      writeLayerEn       = 1'b0;
      unique case (r_state)
         ST_RD_FLAGS: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_FLAGS;
         end
         ST_RD_XPOS: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_XPOS;
         end
         ST_RD_XVEL: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_XVEL;
         end
         ST_WR_XPOS: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_XPOS;
            writeLayerData     = r_acc[ACC_W-1:RES_W];
            writeLayerEn       = ~reset;
         end
         ST_RD_YPOS: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_YPOS;
         end
         ST_RD_YVEL: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_YVEL;
         end
         ST_WR_YPOS: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_YPOS;
            writeLayerData     = r_acc[ACC_W-1:RES_W];
            writeLayerEn       = ~reset;
         end
         ST_RD_FRAME: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_FRAME;
         end
         ST_WR_FRAME: begin
            ctrlReadWriteLayer = r_layer;
            layerRegisterIndex = IDX_FRAME;
            writeLayerData     = {w_nextFrame, r_frameWord[7:0]};
            writeLayerEn       = ~reset;
         end
         default: begin
            ctrlReadWriteLayer = 5'd0;
         end
      endcase
   end

   // Residue updates: cleared for unpopulated layers, replaced on each position write
   always_comb begin
      w_resWe = 1'b0;
      w_resWd = w_resRd;
      unique case (r_state)
         ST_RD_FLAGS: begin
            if (!ctrlReadData[FLAG_POPULATED]) begin
               w_resWe = ~reset;
               w_resWd = '0;
            end
         end
         ST_WR_XPOS: begin
            w_resWe = ~reset;
            w_resWd = {w_resRd[2*RES_W-1:RES_W], r_acc[RES_W-1:0]};
         end
         ST_WR_YPOS: begin
            w_resWe = ~reset;
            w_resWd = {r_acc[RES_W-1:0], w_resRd[RES_W-1:0]};
         end
         default: begin
            w_resWe = 1'b0;
         end
      endcase
   end

   // Datapath registers: layer walk, animation divider, captured header fields
   always_ff @(posedge clk) begin
      if (reset) begin
         r_layer     <= 5'd0;
         r_animCount <= 8'd0;
         r_animTick  <= 1'b0;
         r_animated  <= 1'b0;
         r_pos       <= 16'd0;
         r_acc       <= '0;
         r_frameWord <= 16'd0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= frameStart && (r_state != ST_IDLE);
         if (w_layerEnd) begin
            r_layer <= r_layer + 5'd1;
         end
         unique case (r_state)
            ST_IDLE: begin
               if (frameStart) begin
                  r_animTick  <= (r_animCount == ANIM_LAST);
                  r_animCount <= (r_animCount == ANIM_LAST) ? 8'd0 : r_animCount + 8'd1;
                  r_layer     <= 5'd0;
               end
            end
            ST_RD_FLAGS: r_animated  <= ctrlReadData[FLAG_ANIMATED];
            ST_RD_XPOS:  r_pos       <= ctrlReadData;
            ST_RD_YPOS:  r_pos       <= ctrlReadData;
            ST_RD_XVEL:  r_acc       <= w_accSum;
            ST_RD_YVEL:  r_acc       <= w_accSum;
            ST_RD_FRAME: r_frameWord <= ctrlReadData;
            default:     r_pos       <= r_pos;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_layer_motion_updater.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_motion_updater
// Purpose  : Self-checking bench: header store model, scoreboard of expected
//            header writes, directed scenarios and randomized passes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_motion_updater;

   localparam int VS = 6;
   localparam int AD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        frameStart;
   logic [15:0] ctrlReadData;
   logic [4:0]  ctrlReadWriteLayer;
   logic [2:0]  layerRegisterIndex;
   logic [15:0] writeLayerData;
   logic        writeLayerEn;
   logic        busy;
   logic        updateDone;
   logic        frameOverrun;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int wr_cnt   = 0;
   int frame_wr = 0;

   logic [23:0] q[$];

   // Header store seen by the DUT, plus a host write port used for setup
   logic [15:0] store [32][8];
   logic        h_we = 1'b0;
   logic [4:0]  h_l  = '0;
   logic [2:0]  h_i  = '0;
   logic [15:0] h_d  = '0;

   // Reference model state
   logic [15:0] m_hdr   [32][8];
   logic [15:0] saved   [32][8];
   int          m_res   [32][2];
   int          m_anim  = 0;

   always #5 clk = ~clk;

   layer_motion_updater #(
      .VEL_SHIFT (VS),
      .ANIM_DIV  (AD)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .frameStart         (frameStart),
      .ctrlReadData       (ctrlReadData),
      .ctrlReadWriteLayer (ctrlReadWriteLayer),
      .layerRegisterIndex (layerRegisterIndex),
      .writeLayerData     (writeLayerData),
      .writeLayerEn       (writeLayerEn),
      .busy               (busy),
      .updateDone         (updateDone),
      .frameOverrun       (frameOverrun)
   );

   assign ctrlReadData = store[ctrlReadWriteLayer][layerRegisterIndex];

   always @(posedge clk) begin
      if (writeLayerEn) store[ctrlReadWriteLayer][layerRegisterIndex] <= writeLayerData;
      else if (h_we)    store[h_l][h_i] <= h_d;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every DUT write is popped from the scoreboard and compared
   always begin
      @(negedge clk);
      #2;
      if (!reset) begin
         if (writeLayerEn) begin
            wr_cnt++;
            if (layerRegisterIndex == 3'd7) frame_wr++;
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_write: got l=%0d i=%0d d=%0h expected none",
                        ctrlReadWriteLayer, layerRegisterIndex, writeLayerData);
            end else begin
               logic [23:0] e;
               e = q.pop_front();
               if ({ctrlReadWriteLayer, layerRegisterIndex, writeLayerData} != e) begin
                  failures++;
                  $display("FAIL write: got l=%0d i=%0d d=%0h expected l=%0d i=%0d d=%0h",
                           ctrlReadWriteLayer, layerRegisterIndex, writeLayerData,
                           e[23:19], e[18:16], e[15:0]);
               end
            end
         end
         if (updateDone) begin
            done_cnt++;
            checks++;
            if (q.size() != 0) begin
               failures++;
               $display("FAIL missing_writes: got %0d pending expected 0", q.size());
            end
         end
      end
   end

   // Reference pass computed from header contents with plain integer arithmetic
   task automatic model_pass();
      bit     tick;
      longint t;
      longint M;
      longint S;
      M = longint'(1) << (16 + VS);
      S = longint'(1) << VS;
      tick = (m_anim == AD - 1);
      m_anim = (m_anim + 1) % AD;
      for (int l = 0; l < 32; l++) begin
         logic [15:0] f;
         f = m_hdr[l][0];
         if (!f[0]) begin
            m_res[l][0] = 0;
            m_res[l][1] = 0;
            continue;
         end
         if (!f[1]) continue;
         for (int a = 0; a < 2; a++) begin
            t = longint'(m_hdr[l][3+a]) * S + longint'(m_res[l][a]) + longint'($signed(m_hdr[l][5+a]));
            t = ((t % M) + M) % M;
            m_hdr[l][3+a] = 16'(t / S);
            m_res[l][a]   = int'(t % S);
            q.push_back({5'(l), 3'(3 + a), m_hdr[l][3+a]});
         end
         if (tick && f[3] && m_hdr[l][7][7:0] != 8'd0) begin
            int nf;
            int fr;
            int nx;
            nf = int'(m_hdr[l][7][7:0]);
            fr = int'(m_hdr[l][7][15:8]);
            nx = (fr + 1 >= nf) ? 0 : fr + 1;
            m_hdr[l][7] = {8'(nx), 8'(nf)};
            q.push_back({5'(l), 3'd7, m_hdr[l][7]});
         end
      end
   endtask

   // Host write into store and model (call at a negedge)
   task automatic hw(input int l, input int i, input logic [15:0] d);
      h_we = 1'b1;
      h_l  = 5'(l);
      h_i  = 3'(i);
      h_d  = d;
      m_hdr[l][i] = d;
      @(negedge clk);
      h_we = 1'b0;
   endtask

   task automatic clear_all();
      for (int l = 0; l < 32; l++) begin
         hw(l, 0, 16'h0);
         for (int i = 3; i < 8; i++) hw(l, i, 16'h0);
      end
   endtask

   // One full pass; cyc is the cycle (counted from frameStart) where updateDone shows
   task automatic run_pass(output int cyc);
      model_pass();
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
      cyc = 1;
      while (!updateDone && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (!updateDone) check("pass_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      int cyc;
      int base;
      reset      = 1'b1;
      frameStart = 1'b0;
      for (int l = 0; l < 32; l++) begin
         m_res[l][0] = 0;
         m_res[l][1] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_layer", ctrlReadWriteLayer, 0);
      check("rst_idx",   layerRegisterIndex, 0);
      check("rst_wdata", writeLayerData, 0);
      check("rst_wen",   writeLayerEn, 0);
      check("rst_busy",  busy, 0);
      check("rst_done",  updateDone, 0);
      check("rst_ovr",   frameOverrun, 0);
      reset = 1'b0;
      @(negedge clk);
      clear_all();

      // Animated sprite: frame steps only on the 4th pass
      hw(2, 0, 16'h000B);
      hw(2, 7, 16'h0203);
      for (int p = 1; p <= 4; p++) begin
         run_pass(cyc);
         check("anim_pass_len", cyc, (p == 4) ? 41 : 39);
         check("anim_frame_writes", frame_wr, (p == 4) ? 1 : 0);
      end
      check("anim_frame_value", store[2][7], 16'h0003);
      hw(2, 0, 16'h0000);

      // Sprite layer 5: Xpos 10 + 128/64 = 12
      hw(5, 0, 16'h0003);
      hw(5, 3, 16'd10);
      hw(5, 5, 16'd128);
      check("idle_busy", busy, 0);
      run_pass(cyc);
      check("sprite_pass_len", cyc, 39);
      check("sprite_xpos", store[5][3], 16'd12);

      // Negative velocity: residue carries across passes
      hw(5, 3, 16'd0);
      hw(5, 5, 16'hFFFF);
      run_pass(cyc);
      check("negvel_xpos1", store[5][3], 16'hFFFF);
      run_pass(cyc);
      check("negvel_xpos2", store[5][3], 16'hFFFF);

      // Text layer and unpopulated layer with nonzero velocities: no writes
      hw(5, 0, 16'h0001);
      hw(5, 5, 16'h1234);
      hw(5, 6, 16'h0567);
      hw(6, 0, 16'h0000);
      hw(6, 5, 16'h0100);
      hw(6, 6, 16'h0200);
      base = wr_cnt;
      run_pass(cyc);
      check("text_pass_len", cyc, 33);
      check("text_no_writes", wr_cnt - base, 0);

      // Overrun: frameStart at cycle 10 of a pass is flagged and dropped
      hw(5, 0, 16'h0003);
      base = done_cnt;
      model_pass();
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
      cyc = 1;
      check("busy_rise", busy, 1);
      while (cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
      cyc++;
      check("overrun_pulse", frameOverrun, 1);
      @(negedge clk);
      cyc++;
      check("overrun_clear", frameOverrun, 0);
      while (!updateDone && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check("overrun_pass_len", cyc, 39);
      repeat (50) @(negedge clk);
      check("overrun_single_pass", done_cnt - base, 1);
      check("overrun_idle", busy, 0);

      // Reset during the first position write abandons the pass
      clear_all();
      hw(0, 0, 16'h0003);
      hw(0, 3, 16'd100);
      hw(0, 5, 16'd64);
      saved = m_hdr;
      model_pass();
      frameStart = 1'b1;
      @(negedge clk);
      frameStart = 1'b0;
      cyc = 1;
      while (!writeLayerEn && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_mid_at_wr", cyc, 4);
      reset = 1'b1;
      #1;
      check("rst_mid_we_gate", writeLayerEn, 0);
      @(negedge clk);
      check("rst_mid_wen", writeLayerEn, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_layer", ctrlReadWriteLayer, 0);
      check("rst_mid_store", store[0][3], 16'd100);
      reset = 1'b0;
      q.delete();
      m_hdr  = saved;
      m_anim = 0;
      for (int l = 0; l < 32; l++) begin
         m_res[l][0] = 0;
         m_res[l][1] = 0;
      end
      @(negedge clk);
      run_pass(cyc);
      check("rst_restart_len", cyc, 39);
      check("rst_restart_xpos", store[0][3], 16'd101);

      // Randomized headers over several passes
      for (int r = 0; r < 5; r++) begin
         for (int l = 0; l < 32; l++) begin
            logic [15:0] fl;
            case ($urandom_range(0, 5))
               0: fl = 16'h0000;
               1: fl = 16'h0001;
               2: fl = 16'h0003;
               3: fl = 16'h000B;
               4: fl = 16'h0009;
               default: fl = 16'($urandom);
            endcase
            hw(l, 0, fl);
            hw(l, 3, 16'($urandom));
            hw(l, 4, 16'($urandom));
            hw(l, 5, 16'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 300) - 150));
            hw(l, 6, 16'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 300) - 150));
            hw(l, 7, {8'($urandom_range(0, 1) ? $urandom_range(0, 6) : 255),
                      8'($urandom_range(0, 4))});
         end
         repeat (3) run_pass(cyc);
      end

      check("final_queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
